// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the JTKCPU push/pull sequencer.
//   state_t        sequencer states
//   PSH_*          bit positions of the PSHS/PSHU/PULS/PULU postbyte mask
//   PSH_WIDE_MASK  mask bits that name 16-bit registers
package jtkcpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_PUL  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam int PSH_CC    = 0;
  localparam int PSH_A     = 1;
  localparam int PSH_B     = 2;
  localparam int PSH_DP    = 3;
  localparam int PSH_X     = 4;
  localparam int PSH_Y     = 5;
  localparam int PSH_OTHER = 6;
  localparam int PSH_PC    = 7;

  localparam logic [7:0] PSH_WIDE_MASK = 8'hF0;

  function automatic logic is_wide(input logic [7:0] sel);
    return |(sel & PSH_WIDE_MASK);
  endfunction

endpackage

// File: rtl/jtkcpu_pshpul_if.sv
// Byte-wide memory bus used by the push/pull sequencer.
//   bus_req/bus_we/bus_addr/bus_dout  driven by the master (sequencer)
//   bus_din/bus_ack                   driven by the slave (memory side)
interface jtkcpu_pshpul_if;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_dout,
    input  bus_din, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/jtkcpu_pshpul_pick.sv
// One-hot isolation of a single set bit of a register mask.
//   mask    in   8  candidate bits
//   dir     in   1  1 = keep highest set bit (push order), 0 = lowest (pull order)
//   onehot  out  8  isolated bit, 0 when mask is 0
module jtkcpu_pshpul_pick (
  input  logic [7:0] mask,
  input  logic       dir,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = 8'h00;
    if (dir) begin
      // ascending scan: the last hit is the highest bit
      for (int i = 0; i < 8; i++)
        if (mask[i]) onehot = 8'h01 << i;
    end else begin
      for (int i = 7; i >= 0; i--)
        if (mask[i]) onehot = 8'h01 << i;
    end
  end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// PSHS/PSHU/PULS/PULU sequencer: walks the postbyte mask one register and
// one byte at a time, strobing the register file and running bus cycles.
//   clk, rst (async, active-high), cen       clocking
//   start_psh/start_pul/postbyte            command, sampled in IDLE
//   psh_addr/psh_mux                        stack pointer and byte to push
//   psh_sel/psh_hilon/pshdec/pul_en/pul_data register file strobes
//   bus                                     memory bus (master side)
//   busy/done                               sequence status
//
// state | meaning
// IDLE  | waiting for a start command
// DEC   | stack pointer pre-decrement before a write
// WR    | write current byte, wait for ack
// RD    | read current byte, wait for ack
// PUL   | load pulled byte into register, post-increment stack
// DONE  | one-cycle completion pulse
module jtkcpu_pshpul
  import jtkcpu_pkg::*;
(
  input  logic             rst,
  input  logic             clk,
  input  logic             cen,
  input  logic             start_psh,
  input  logic             start_pul,
  input  logic [7:0]       postbyte,
  input  logic [15:0]      psh_addr,
  input  logic [7:0]       psh_mux,
  output logic [7:0]       psh_sel,
  output logic             psh_hilon,
  output logic             pshdec,
  output logic             pul_en,
  output logic [7:0]       pul_data,
  output logic             busy,
  output logic             done,
  jtkcpu_pshpul_if.master  bus
);

  state_t     state, state_nx;
  logic [7:0] mask, mask_nx, mask_clr;
  logic [7:0] sel_nx, pick_in, pick_out;
  logic       hilon_nx, pul_mode, pul_mode_nx, pick_dir, adv;
  logic       req_q, we_q;

  assign mask_clr = mask & ~psh_sel;

  // In IDLE the next register comes straight from the postbyte, otherwise
  // from the mask with the current register already removed.
  assign pick_in  = (state == ST_IDLE) ? postbyte  : mask_clr;
  assign pick_dir = (state == ST_IDLE) ? start_psh : ~pul_mode;

  jtkcpu_pshpul_pick u_pick (
    .mask   (pick_in),
    .dir    (pick_dir),
    .onehot (pick_out)
  );

  always_comb begin
    state_nx    = state;
    mask_nx     = mask;
    sel_nx      = psh_sel;
    hilon_nx    = psh_hilon;
    pul_mode_nx = pul_mode;
    adv         = 1'b0;
    case (state)
      ST_IDLE: if (start_psh || start_pul) begin
        mask_nx     = postbyte;
        pul_mode_nx = ~start_psh;
        sel_nx      = pick_out;
        hilon_nx    = ~start_psh & is_wide(pick_out);
        if (postbyte == 8'h00) state_nx = ST_DONE;
        else                   state_nx = start_psh ? ST_DEC : ST_RD;
      end
      ST_DEC:  state_nx = ST_WR;
      ST_WR:   if (bus.bus_ack) begin
        if (is_wide(psh_sel) && !psh_hilon) begin
          hilon_nx = 1'b1;
          state_nx = ST_DEC;
        end else adv = 1'b1;
      end
      ST_RD:   if (bus.bus_ack) state_nx = ST_PUL;
      ST_PUL:  begin
        if (is_wide(psh_sel) && psh_hilon) begin
          hilon_nx = 1'b0;
          state_nx = ST_RD;
        end else adv = 1'b1;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        sel_nx   = 8'h00;
        hilon_nx = 1'b0;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (adv) begin
      mask_nx = mask_clr;
      if (mask_clr == 8'h00) begin
        state_nx = ST_DONE;
        sel_nx   = 8'h00;
        hilon_nx = 1'b0;
      end else begin
        state_nx = pul_mode ? ST_RD : ST_DEC;
        sel_nx   = pick_out;
        hilon_nx = pul_mode & is_wide(pick_out);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mask      <= 8'h00;
      psh_sel   <= 8'h00;
      psh_hilon <= 1'b0;
      pul_mode  <= 1'b0;
      pshdec    <= 1'b0;
      pul_en    <= 1'b0;
      pul_data  <= 8'h00;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (cen) begin
      state     <= state_nx;
      mask      <= mask_nx;
      psh_sel   <= sel_nx;
      psh_hilon <= hilon_nx;
      pul_mode  <= pul_mode_nx;
      pshdec    <= (state_nx == ST_DEC);
      pul_en    <= (state_nx == ST_PUL);
      req_q     <= (state_nx == ST_WR) || (state_nx == ST_RD);
      we_q      <= (state_nx == ST_WR);
      busy      <= (state_nx != ST_IDLE);
      done      <= (state_nx == ST_DONE);
      if (state == ST_RD && bus.bus_ack) pul_data <= bus.bus_din;
    end
  end

  // Address and data follow the register file directly; zeroed when idle.
  assign bus.bus_req  = req_q;
  assign bus.bus_we   = we_q;
  assign bus.bus_addr = req_q ? psh_addr : 16'h0000;
  assign bus.bus_dout = (req_q && we_q) ? psh_mux : 8'h00;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
module tb_jtkcpu_pshpul;

  logic        clk, rst;
  logic        cen = 1'b1;
  logic        start_psh, start_pul;
  logic [7:0]  postbyte;
  logic [15:0] psh_addr;
  logic [7:0]  psh_mux;
  logic [7:0]  psh_sel;
  logic        psh_hilon, pshdec, pul_en, busy, done;
  logic [7:0]  pul_data;

  jtkcpu_pshpul_if bus ();

  jtkcpu_pshpul dut (
    .rst(rst), .clk(clk), .cen(cen),
    .start_psh(start_psh), .start_pul(start_pul), .postbyte(postbyte),
    .psh_addr(psh_addr), .psh_mux(psh_mux),
    .psh_sel(psh_sel), .psh_hilon(psh_hilon), .pshdec(pshdec),
    .pul_en(pul_en), .pul_data(pul_data), .busy(busy), .done(done),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  // register file model
  function automatic logic [7:0] reg_byte(input int b, input bit h);
    logic [15:0] w;
    case (b)
      0: return 8'h5A;
      1: return 8'h11;
      2: return 8'h22;
      3: return 8'h33;
      4: w = 16'h2345;
      5: w = 16'h789A;
      6: w = 16'h4567;
      default: w = 16'h1234;
    endcase
    return h ? w[15:8] : w[7:0];
  endfunction

  always_comb begin
    psh_mux = 8'h00;
    for (int b = 0; b < 8; b++)
      if (psh_sel[b]) psh_mux = reg_byte(b, psh_hilon);
  end

  // stack pointer model
  logic [15:0] s;
  logic        s_load;
  logic [15:0] s_val;
  always @(posedge clk) begin
    if (s_load) s <= s_val;
    else if (cen) begin
      if (pshdec)      s <= s - 16'd1;
      else if (pul_en) s <= s + 16'd1;
    end
  end
  assign psh_addr = s;

  // memory with programmable ack delay
  logic [7:0] mem [0:65535];
  int ack_delay;
  int wait_cnt;
  assign bus.bus_din = mem[bus.bus_addr];
  assign bus.bus_ack = bus.bus_req && (wait_cnt >= ack_delay);
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!bus.bus_req || (bus.bus_ack && cen)) wait_cnt <= 0;
    else if (cen) wait_cnt <= wait_cnt + 1;
  end

  bit cen_toggle;
  always @(posedge clk) begin
    #2;
    cen = cen_toggle ? ~cen : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_s(input logic [15:0] v);
    @(negedge clk);
    s_load = 1'b1;
    s_val  = v;
    @(posedge clk);
    #1 s_load = 1'b0;
  endtask

  typedef struct {
    bit          psh;
    bit          both;
    logic [7:0]  pb;
    logic [15:0] s0;
    int          cyc;      // expected done cycle, 0 = not timed
    logic [15:0] s_end;
    int          nbytes;
    bit          commit;   // copy written bytes into the memory model
  } vec_t;

  vec_t vt[7];

  int          exp_b[$];
  bit          exp_h[$];
  logic [7:0]  ev_sel[$];
  bit          ev_h[$];
  logic [15:0] ev_addr[$];
  logic [7:0]  ev_data[$];

  task automatic build_seq(input bit psh, input logic [7:0] pb);
    exp_b.delete();
    exp_h.delete();
    if (psh) begin
      for (int b = 7; b >= 0; b--) if (pb[b]) begin
        exp_b.push_back(b); exp_h.push_back(1'b0);
        if (b >= 4) begin exp_b.push_back(b); exp_h.push_back(1'b1); end
      end
    end else begin
      for (int b = 0; b < 8; b++) if (pb[b]) begin
        if (b >= 4) begin exp_b.push_back(b); exp_h.push_back(1'b1); end
        exp_b.push_back(b); exp_h.push_back(1'b0);
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int done_cyc, busy_cnt, breq_cnt, dec_cnt, stable_bad, n;
    bit have_prev;
    logic [15:0] prev_addr;
    logic [7:0]  prev_dout;
    load_s(v.s0);
    build_seq(v.psh, v.pb);
    ev_sel.delete(); ev_h.delete(); ev_addr.delete(); ev_data.delete();
    done_cyc = -1; busy_cnt = 0; breq_cnt = 0; dec_cnt = 0; stable_bad = 0;
    have_prev = 1'b0; prev_addr = '0; prev_dout = '0;
    @(negedge clk);
    postbyte  = v.pb;
    start_psh = v.psh;
    start_pul = !v.psh || v.both;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        start_psh = 1'b0;
        start_pul = 1'b0;
        postbyte  = ~v.pb;
      end
      if (i == 1 && v.cyc > 3) begin
        start_psh = 1'b1;
        start_pul = 1'b1;
      end
      @(negedge clk);
      if (cen) begin
        if (busy)        busy_cnt++;
        if (bus.bus_req) breq_cnt++;
        if (pshdec)      dec_cnt++;
        if (bus.bus_req && bus.bus_we && bus.bus_ack) begin
          ev_sel.push_back(psh_sel); ev_h.push_back(psh_hilon);
          ev_addr.push_back(bus.bus_addr); ev_data.push_back(bus.bus_dout);
        end
        if (pul_en) begin
          ev_sel.push_back(psh_sel); ev_h.push_back(psh_hilon);
          ev_addr.push_back(16'h0000); ev_data.push_back(pul_data);
        end
      end
      if (have_prev && bus.bus_req &&
          (bus.bus_addr !== prev_addr || bus.bus_dout !== prev_dout)) stable_bad++;
      have_prev = bus.bus_req && !(bus.bus_ack && cen);
      prev_addr = bus.bus_addr;
      prev_dout = bus.bus_dout;
      if (done && cen) begin
        done_cyc = i + 1;
        break;
      end
    end
    start_psh = 1'b0;
    start_pul = 1'b0;
    if (done_cyc < 0) check({tag, " done timeout"}, 64'd0, 64'd1);
    repeat (v.cyc > 0 ? 1 : 3) @(posedge clk);
    #1;
    check({tag, " busy/done low after"}, {busy, done}, 2'b00);
    if (v.cyc > 0) begin
      check({tag, " done cycle"}, done_cyc, v.cyc);
      check({tag, " busy cycles"}, busy_cnt, v.cyc);
      check({tag, " bus_req cycles"}, breq_cnt, v.nbytes);
    end
    check({tag, " final stack"}, s, v.s_end);
    check({tag, " byte count"}, ev_sel.size(), v.nbytes);
    check({tag, " pshdec count"}, dec_cnt, v.psh ? v.nbytes : 0);
    check({tag, " bus stable"}, stable_bad, 0);
    n = (ev_sel.size() < exp_b.size()) ? ev_sel.size() : exp_b.size();
    for (int k = 0; k < n; k++) begin
      logic [15:0] ea;
      logic [7:0]  ed;
      if (v.psh) begin
        ea = v.s0 - 16'(k + 1);
        ed = reg_byte(exp_b[k], exp_h[k]);
      end else begin
        ea = 16'h0000;
        ed = mem[v.s0 + 16'(k)];
      end
      check($sformatf("%s byte %0d sel/hilon/addr/data", tag, k),
            {ev_sel[k], ev_h[k], ev_addr[k], ev_data[k]},
            {8'h01 << exp_b[k], exp_h[k], ea, ed});
    end
    if (v.commit)
      for (int k = 0; k < ev_sel.size(); k++) mem[ev_addr[k]] = ev_data[k];
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'h81, 16'h1000,  7, 16'h0FFD,  3, 1'b0};
    vt[1] = '{1'b0, 1'b0, 8'h06, 16'h0FFD,  5, 16'h0FFF,  2, 1'b0};
    vt[2] = '{1'b0, 1'b0, 8'h10, 16'h2000,  5, 16'h2002,  2, 1'b0};
    vt[3] = '{1'b1, 1'b0, 8'h00, 16'h1000,  1, 16'h1000,  0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 8'hFF, 16'h3000, 25, 16'h2FF4, 12, 1'b1};
    vt[5] = '{1'b0, 1'b0, 8'hFF, 16'h2FF4, 25, 16'h3000, 12, 1'b0};
    vt[6] = '{1'b1, 1'b1, 8'h04, 16'h1000,  3, 16'h0FFF,  1, 1'b0};

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0FFD] = 8'h11;
    mem[16'h0FFE] = 8'h22;
    mem[16'h2000] = 8'hAB;
    mem[16'h2001] = 8'hCD;

    rst = 1'b1; start_psh = 1'b0; start_pul = 1'b0; postbyte = 8'h00;
    ack_delay = 0; cen_toggle = 1'b0; s_load = 1'b0; s_val = 16'h0000;
    #1;
    check("reset outputs",
          {psh_sel, psh_hilon, pshdec, pul_en, pul_data, bus.bus_req, bus.bus_we,
           bus.bus_addr, bus.bus_dout, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // delayed ack with cen running at half rate
    ack_delay  = 3;
    cen_toggle = 1'b1;
    run_vec("slow", '{1'b1, 1'b0, 8'h02, 16'h1000, 0, 16'h0FFF, 1, 1'b0});
    cen_toggle = 1'b0;
    ack_delay  = 0;
    repeat (3) @(posedge clk);

    // reset in the middle of a write
    ack_delay = 2;
    load_s(16'h1000);
    @(negedge clk);
    postbyte = 8'h83; start_psh = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (busy) start_psh = 1'b0;
        @(negedge clk);
        if (bus.bus_req && bus.bus_we) seen = 1'b1;
      end
      start_psh = 1'b0;
      check("reached WR before reset", seen, 1'b1);
    end
    rst = 1'b1;
    #1;
    check("outputs during mid-WR reset",
          {psh_sel, psh_hilon, pshdec, pul_en, pul_data, bus.bus_req, bus.bus_we,
           bus.bus_addr, bus.bus_dout, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    run_vec("after reset", vt[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtkcpu_pshpul.md
Name: jtkcpu_pshpul

Overview:
- Sequencer for PSHS/PSHU/PULS/PULU (and the interrupt push/RTI pull) in the JTKCPU core.
- Walks the postbyte register mask one register, one byte at a time.
- Drives the register file's push/pull select, byte-half, stack-decrement and pull-enable strobes.
- Runs the byte-wide memory bus transactions with a req/ack handshake.

Parameters:
- None.

Ports:
- rst  in  1  asynchronous, active-high reset
- clk  in  1  clock
- cen  in  1  clock enable; all state and strobes advance only when high
- start_psh  in  1  begin push of postbyte mask (sampled in IDLE)
- start_pul  in  1  begin pull of postbyte mask (sampled in IDLE)
- postbyte  in  8  register mask: b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 other stack ptr, b7 PC
- psh_addr  in  16  current stack pointer value from register file
- psh_mux  in  8  byte to push, from register file for current psh_sel/psh_hilon
- psh_sel  out  8  one-hot select of current register (0 when idle)
- psh_hilon  out  1  1 = high byte of 16-bit register, 0 = low byte
- pshdec  out  1  decrement stack pointer (one cen cycle)
- pul_en  out  1  load pul_data into selected register and post-increment stack pointer (one cen cycle)
- pul_data  out  8  byte captured on last pull read
- bus_req  out  1  memory request
- bus_we  out  1  1 = write
- bus_addr  out  16  memory address
- bus_dout  out  8  write data
- bus_din  in  8  read data, valid with bus_ack
- bus_ack  in  1  transaction complete (sampled with cen)
- busy  out  1  sequence in progress
- done  out  1  one cen-cycle pulse at end of sequence

Behaviour:
- Reset (async): state IDLE; mask, psh_sel, psh_hilon, pshdec, pul_en, pul_data, bus_req, bus_we, bus_addr, bus_dout, busy, done all 0.
- cen low: state and registered outputs hold; bus_ack ignored.
- States: IDLE, DEC, WR, RD, PUL, DONE. Outputs are registered except bus_addr and bus_dout.
- IDLE:
  - On start_psh, latch postbyte into mask and go to DEC.
  - On start_pul, latch postbyte and go to RD.
  - If both starts are asserted, push wins.
  - If the latched mask is 0, go to DONE instead, with no bus activity.
  - busy rises with the transition.
- Push order: highest set bit first (PC, other, Y, X, DP, B, A, CC).
  - 16-bit registers: low byte (hilon=0) first, then high.
  - Pull order: lowest set bit first; 16-bit registers high byte (hilon=1) first, then low.
  - psh_sel is the isolated current bit; psh_hilon starts at 0 for push and at 1 for pull when the register is bits 4-7, and is 0 for bits 0-3.
- DEC: pshdec=1 for exactly one cen cycle, then WR.
- WR: bus_req=1, bus_we=1, bus_addr=psh_addr (already decremented), bus_dout=psh_mux. Hold until bus_ack, then:
  - 16-bit register with hilon=0: set hilon=1, go to DEC.
  - Otherwise clear the bit from mask and go to DEC for the next bit, or to DONE if mask is empty.
- RD: bus_req=1, bus_we=0, bus_addr=psh_addr. On bus_ack, latch bus_din into pul_data and go to PUL.
- PUL: pul_en=1 for one cen cycle, then:
  - 16-bit register with hilon=1: set hilon=0, go to RD.
  - Otherwise clear the bit and go to RD, or to DONE if mask is empty.
- DONE: done=1 for one cycle; psh_sel=0; then IDLE. busy stays high through DONE and falls on entry to IDLE.
- Start pulses while busy are ignored.
- bus_req deasserts the cycle after ack.
- With zero-wait ack, throughput is 2 cen cycles per byte. Latency from start to done is 2·bytes+1 cycles.
- postbyte changes mid-sequence have no effect, since mask is latched.

Decomposition:
- Shared package jtkcpu_pkg holds:
  - state encodings;
  - mask bit indices PSH_CC, PSH_A, PSH_B, PSH_DP, PSH_X, PSH_Y, PSH_OTHER, PSH_PC;
  - the constant PSH_WIDE_MASK = 8'hF0.
- One sub-module, jtkcpu_pshpul_pick: combinational one-hot isolation of the highest or lowest set bit, selected by a dir input.

Test Plan:
- Push 0x81, bench stack model S=0x1000 decrementing on pshdec, PC=0x1234, CC=0x5A, immediate ack -> writes 0x0FFF=0x34, 0x0FFE=0x12, 0x0FFD=0x5A; three pshdec pulses; done at cycle 7.
- Pull 0x06, S=0x0FFD, mem[0x0FFD]=0x11, mem[0x0FFE]=0x22 -> pul_en with psh_sel=0x02 and pul_data=0x11, then psh_sel=0x04 and pul_data=0x22; done at cycle 5.
- Pull 0x10, mem[0x2000]=0xAB, mem[0x2001]=0xCD -> first pul_en with hilon=1 and data 0xAB, second with hilon=0 and data 0xCD.
- Start with postbyte 0x00 -> done at cycle 1, bus_req never asserted, busy high for one cycle.
- Push 0x02 with ack delayed 3 cycles and cen toggling every other clk -> bus_req, bus_addr and bus_dout stable until ack, exactly one pshdec.
- Assert rst during WR of a 3-register push -> all outputs 0 immediately; a new start_pul afterwards runs normally.
